// File: rtl/apb_rambus_bridge.sv
// APB3 completer that converts fabric APB transfers into RamBus cycles for
// the DM main-ports register file, returning prdata, pready and pslverr.
// Optional macro RAMBUS_TIMEOUT_EN: abort a WAIT that sees no ack within
// TIMEOUT_CYCLES cycles, flag pslverr and count the aborts.
module apb_rambus_bridge #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter logic [DATA_WIDTH-1:0] ERR_READ_DATA = 32'hDEADBEEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic [ADDR_WIDTH-1:0] rb_address,
    output logic [DATA_WIDTH-1:0] rb_data_out,
    input  logic [DATA_WIDTH-1:0] rb_data_in,
    output logic                  rb_ncs,
    output logic                  rb_wrnrd,
    output logic                  rb_latch,
    input  logic                  rb_ack,
    output logic                  busy,
    output logic [7:0]            timeout_count
);

    typedef enum logic [1:0] {IDLE, STROBE, WAIT, DONE} state_t;

    state_t state;
    state_t state_next;
    logic   setup_seen;
    logic   ack_hit;
    logic   abort_hit;

    assign setup_seen = (state == IDLE) && psel && !penable;
    assign ack_hit    = (state == WAIT) && rb_ack;

`ifdef RAMBUS_TIMEOUT_EN
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wait_count;
    logic       err_flag;

    // ack wins over a timeout that expires in the same cycle
    assign abort_hit = (state == WAIT) && !rb_ack && (wait_count == WAIT_LAST);

    // WAIT cycle counter, abort flag for the current transfer, abort tally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_count    <= 8'h00;
            err_flag      <= 1'b0;
            timeout_count <= 8'h00;
        end else begin
            if (state == STROBE)
                wait_count <= 8'h00;
            else if (state == WAIT)
                wait_count <= wait_count + 8'h01;
            if (setup_seen)
                err_flag <= 1'b0;
            else if (abort_hit)
                err_flag <= 1'b1;
            if (abort_hit && (timeout_count != 8'hFF))
                timeout_count <= timeout_count + 8'h01;
        end
    end

    assign pslverr = pready && err_flag;
`else
    logic unused_params;

    assign abort_hit     = 1'b0;
    assign pslverr       = 1'b0;
    assign timeout_count = 8'h00;
    assign unused_params = ^{8'(TIMEOUT_CYCLES), ERR_READ_DATA};
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic; DONE always returns to IDLE even if APB went away
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (setup_seen) state_next = STROBE;
            STROBE:  state_next = WAIT;
            WAIT:    if (ack_hit || abort_hit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Transfer capture at setup, held stable until the next setup
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rb_address  <= '0;
            rb_data_out <= '0;
            rb_wrnrd    <= 1'b0;
        end else if (setup_seen) begin
            rb_address  <= paddr;
            rb_data_out <= pwdata;
            rb_wrnrd    <= pwrite;
        end
    end

    // Read data capture; writes leave prdata untouched
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            prdata <= '0;
        else if (ack_hit && !rb_wrnrd)
            prdata <= rb_data_in;
        else if (abort_hit && !rb_wrnrd)
            prdata <= ERR_READ_DATA;
    end

    assign rb_ncs   = !((state == STROBE) || (state == WAIT));
    assign rb_latch = (state == STROBE);
    assign busy     = (state != IDLE);
    assign pready   = (state == DONE) && psel && penable;

endmodule

// File: tb/tb_apb_rambus_bridge.sv
// Self-checking bench for apb_rambus_bridge. Inputs are driven and outputs
// sampled on the falling clock edge. Define RAMBUS_TIMEOUT_EN for both the
// RTL and this bench to exercise the abort path.
module tb_apb_rambus_bridge;

    localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [13:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [13:0] rb_address;
    logic [31:0] rb_data_out;
    logic [31:0] rb_data_in;
    logic        rb_ncs;
    logic        rb_wrnrd;
    logic        rb_latch;
    logic        rb_ack;
    logic        busy;
    logic [7:0]  timeout_count;

    typedef struct packed {
        logic [31:0] prdata;
        logic        pslverr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_prdata;
    int          vectors = 0;
    int          miscompares = 0;

    apb_rambus_bridge #(
        .ADDR_WIDTH(14),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(8),
        .ERR_READ_DATA(ERR_DATA)
    ) dut (
        .clk(clk),
        .rst(rst),
        .psel(psel),
        .penable(penable),
        .pwrite(pwrite),
        .paddr(paddr),
        .pwdata(pwdata),
        .prdata(prdata),
        .pready(pready),
        .pslverr(pslverr),
        .rb_address(rb_address),
        .rb_data_out(rb_data_out),
        .rb_data_in(rb_data_in),
        .rb_ncs(rb_ncs),
        .rb_wrnrd(rb_wrnrd),
        .rb_latch(rb_latch),
        .rb_ack(rb_ack),
        .busy(busy),
        .timeout_count(timeout_count)
    );

    always #5 clk = ~clk;

    // One APB transfer with a modelled register-file responder. n_wait is the
    // number of WAIT cycles; with give_ack the ack is seen in the last one.
    task automatic run_transfer(input logic wr, input logic [13:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                input int n_wait, input bit give_ack,
                                input bit drop_psel, input string name);
        int   latch_seen;
        int   ncs_low;
        bit   stable_ok;
        exp_t got;
        @(negedge clk);
        vectors++;
        if ({rb_ncs, busy} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL %s idle_before_setup: ncs,busy=%b required 10", name, {rb_ncs, busy});
        end
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        rb_data_in = rdata; rb_ack = 1'b0;
        if (!wr) model_prdata = give_ack ? rdata : ERR_DATA;
        if (!drop_psel) exp_q.push_back('{prdata: model_prdata, pslverr: !give_ack});
        latch_seen = 0; ncs_low = 0; stable_ok = 1'b1;
        @(negedge clk);
        penable = 1'b1;
        latch_seen += int'(rb_latch);
        ncs_low += int'(!rb_ncs);
        if (rb_address !== addr || rb_data_out !== wdata || rb_wrnrd !== wr) stable_ok = 1'b0;
        for (int k = 1; k <= n_wait; k++) begin
            @(negedge clk);
            latch_seen += int'(rb_latch);
            ncs_low += int'(!rb_ncs);
            if (rb_address !== addr || rb_data_out !== wdata || rb_wrnrd !== wr) stable_ok = 1'b0;
            if (drop_psel && k == 1) begin
                psel = 1'b0; penable = 1'b0;
            end
            if (give_ack && k == n_wait) rb_ack = 1'b1;
        end
        @(negedge clk);
        rb_ack = 1'b0;
        latch_seen += int'(rb_latch);
        if (rb_address !== addr || rb_data_out !== wdata || rb_wrnrd !== wr) stable_ok = 1'b0;
        vectors += 4;
        if (latch_seen != 1) begin
            miscompares++;
            $display("[TB] FAIL %s latch_pulses: got %0d required 1", name, latch_seen);
        end
        if (ncs_low != n_wait + 1) begin
            miscompares++;
            $display("[TB] FAIL %s ncs_low_cycles: got %0d required %0d", name, ncs_low, n_wait + 1);
        end
        if (stable_ok !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL %s addr_data_dir_stable: got %b required 1", name, stable_ok);
        end
        if ({rb_ncs, pready} !== {1'b1, !drop_psel}) begin
            miscompares++;
            $display("[TB] FAIL %s done_ncs_pready: got %b required %b", name, {rb_ncs, pready}, {1'b1, !drop_psel});
        end
        if (pready === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL %s scoreboard: pready with no expected entry", name);
            end else begin
                got = exp_q.pop_front();
                if (prdata !== got.prdata || pslverr !== got.pslverr) begin
                    miscompares++;
                    $display("[TB] FAIL %s response: prdata=%h pslverr=%b required prdata=%h pslverr=%b",
                             name, prdata, pslverr, got.prdata, got.pslverr);
                end
            end
        end else if (!drop_psel && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
        end
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        rb_data_in = '0; rb_ack = 1'b0; model_prdata = '0;
        #12;
        vectors++;
        if ({rb_ncs, rb_latch, rb_wrnrd, pready, pslverr, busy} !== 6'b100000 ||
            rb_address !== 14'h0 || rb_data_out !== 32'h0 || prdata !== 32'h0 || timeout_count !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL reset_state: ncs,latch,wrnrd,pready,pslverr,busy=%b addr=%h wdata=%h prdata=%h tcount=%h required 100000/0/0/0/0",
                     {rb_ncs, rb_latch, rb_wrnrd, pready, pslverr, busy}, rb_address, rb_data_out, prdata, timeout_count);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_write;
        run_transfer(1'b1, 14'h0010, 32'hA5A5_0001, 32'h0000_0055, 3, 1'b1, 1'b0, "write");
    endtask

    task automatic test_read;
        run_transfer(1'b0, 14'h0004, 32'h0000_0000, 32'h1234_5678, 1, 1'b1, 1'b0, "read");
    endtask

    task automatic test_back_to_back;
        run_transfer(1'b1, 14'h0008, 32'hCAFE_0008, 32'h0000_00AA, 2, 1'b1, 1'b0, "b2b_write");
        run_transfer(1'b0, 14'h000C, 32'h0000_0000, 32'h0BAD_F00D, 1, 1'b1, 1'b0, "b2b_read");
    endtask

`ifdef RAMBUS_TIMEOUT_EN
    task automatic test_timeout;
        run_transfer(1'b0, 14'h0030, 32'h0000_0000, 32'h1111_2222, 8, 1'b0, 1'b0, "timeout_read");
        vectors++;
        if (timeout_count !== 8'h01) begin
            miscompares++;
            $display("[TB] FAIL timeout_count: got %h required 01", timeout_count);
        end
        @(negedge clk);
        rb_ack = 1'b1;
        @(negedge clk);
        rb_ack = 1'b0;
        vectors++;
        if ({busy, rb_ncs, pready} !== 3'b010 || prdata !== ERR_DATA || timeout_count !== 8'h01) begin
            miscompares++;
            $display("[TB] FAIL stray_ack: busy,ncs,pready=%b prdata=%h tcount=%h required 010/%h/01",
                     {busy, rb_ncs, pready}, prdata, timeout_count, ERR_DATA);
        end
    endtask
`endif

    task automatic test_reset_mid_transfer;
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 14'h0020; pwdata = 32'h7777_0020;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        vectors++;
        if (rb_ncs !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL pre_reset_wait: ncs,busy=%b required 01", {rb_ncs, busy});
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({rb_ncs, busy, pready, rb_latch} !== 4'b1000 || prdata !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_wait: ncs,busy,pready,latch=%b prdata=%h required 1000/0",
                     {rb_ncs, busy, pready, rb_latch}, prdata);
        end
        model_prdata = '0;
        @(negedge clk);
        rst = 1'b0; psel = 1'b0; penable = 1'b0;
        run_transfer(1'b0, 14'h0024, 32'h0, 32'h5A5A_0024, 2, 1'b1, 1'b0, "after_reset_read");
    endtask

    task automatic test_psel_drop;
        run_transfer(1'b1, 14'h0028, 32'h3333_0028, 32'h0, 2, 1'b1, 1'b1, "psel_drop");
        run_transfer(1'b0, 14'h002C, 32'h0, 32'h4444_002C, 1, 1'b1, 1'b0, "after_drop_read");
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_back_to_back;
`ifdef RAMBUS_TIMEOUT_EN
        test_timeout;
`endif
        test_reset_mid_transfer;
        test_psel_drop;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/apb_rambus_bridge.md
Name: apb_rambus_bridge

Overview:
APB3 completer that turns MSS fabric-interface APB transfers into RamBus cycles for the DM main-ports register file, and returns read data, PREADY and PSLVERR.
Sits between the MSS AMBA slave port and the register-file RamBus inputs. Supplies a correct active-low chip-select, a single-cycle latch strobe and ack-driven wait states.
Both sides share one clock.

Parameters:
ADDR_WIDTH, 14, width of paddr and rb_address
DATA_WIDTH, 32, width of the APB and RamBus data paths
TIMEOUT_CYCLES, 255, WAIT cycles without ack before abort (used only with RAMBUS_TIMEOUT_EN)
ERR_READ_DATA, 32'hDEADBEEF, prdata value returned on an aborted read

Ports:
clk  in  1  fabric clock; all logic on rising edge
rst  in  1  asynchronous reset, active-high
psel  in  1  APB select
penable  in  1  APB enable (access phase)
pwrite  in  1  APB direction, 1 = write
paddr  in  ADDR_WIDTH  APB address
pwdata  in  DATA_WIDTH  APB write data
prdata  out  DATA_WIDTH  APB read data
pready  out  1  APB ready, one-cycle pulse
pslverr  out  1  APB error, valid with pready
rb_address  out  ADDR_WIDTH  RamBus address (registered)
rb_data_out  out  DATA_WIDTH  RamBus write data (registered)
rb_data_in  in  DATA_WIDTH  RamBus read data from the register file
rb_ncs  out  1  RamBus chip select, active-low
rb_wrnrd  out  1  RamBus direction, 1 = write
rb_latch  out  1  RamBus strobe, one cycle per transfer
rb_ack  in  1  RamBus completion from the register file
busy  out  1  high in any state other than IDLE
timeout_count  out  8  saturating count of aborted transfers

Behaviour:
- Reset (async, immediate, also mid-transfer): state=IDLE; rb_ncs=1, rb_latch=0, rb_wrnrd=0; rb_address=0, rb_data_out=0; prdata=0; pready=0, pslverr=0; busy=0; timeout_count=0. An interrupted RamBus cycle is abandoned, with no pready.
- States:
  - IDLE: on psel=1 and penable=0, capture paddr, pwdata and pwrite into rb_address, rb_data_out and rb_wrnrd, then go to STROBE.
  - STROBE: exactly one cycle; rb_ncs=0, rb_latch=1. Go to WAIT.
  - WAIT: rb_ncs=0, rb_latch=0. When rb_ack=1 is sampled, capture rb_data_in into prdata if this is a read, then go to DONE.
  - DONE: one cycle; rb_ncs=1. pready=1 only if psel=1 and penable=1 this cycle; otherwise the result is discarded silently. Go to IDLE.
- Latency: setup edge at T0, STROBE at T1, earliest ack sampled at T2, pready at T3. Minimum is 2 APB wait states.
- rb_ack is ignored in IDLE, STROBE and DONE.
- rb_address, rb_data_out and rb_wrnrd are held stable from STROBE through DONE.
- Back-to-back transfers: a new setup phase in the cycle after DONE is accepted from IDLE with no bubble beyond that cycle.
- Writes leave prdata unchanged. pslverr=0 unless timeout.
- psel dropped mid-transfer (protocol violation): the RamBus cycle still completes normally and no pready is issued.
- timeout_count saturates at 8'hFF and never wraps.

Optional Feature:
RAMBUS_TIMEOUT_EN
- Defined: an 8-bit counter runs in WAIT and clears on entry to WAIT.
  - If the count reaches TIMEOUT_CYCLES without ack, go to DONE with pslverr=1 and increment timeout_count.
  - On a read, prdata=ERR_READ_DATA.
  - A late ack arriving after the abort is ignored.
- Undefined: WAIT holds indefinitely until ack; pslverr is tied to 0; timeout_count is tied to 0.

Test Plan:
- Write paddr=14'h0010, pwdata=32'hA5A5_0001, ack 3 cycles after STROBE -> one rb_latch pulse; rb_ncs low for 4 cycles; rb_wrnrd=1 with address and data stable; pready 1 cycle after ack, pslverr=0.
- Read paddr=14'h0004, rb_data_in=32'h1234_5678, ack on the first WAIT cycle -> pready at T3 with prdata=32'h1234_5678; rb_wrnrd=0.
- Back-to-back write then read to 14'h0008 and 14'h000C -> two distinct latch pulses; rb_ncs returns high for at least 1 cycle between them; both complete, with the read returning rb_data_in.
- With RAMBUS_TIMEOUT_EN and TIMEOUT_CYCLES=8, read with ack never asserted -> pready and pslverr together after 8 WAIT cycles; prdata=32'hDEADBEEF; timeout_count=1; a later stray ack has no effect.
- Assert rst during WAIT -> in the same cycle rb_ncs=1, busy=0 and pready=0. The next transfer completes normally.
- Drop psel during WAIT, then ack -> RamBus cycle ends (rb_ncs=1), no pready; bridge returns to IDLE and accepts the next setup.
